// File: rtl/guess_game_ctrl_if.sv
// Signal bundle between the round controller and its environment.
// The environment drives start/ans_in/guess_valid/count_in; the controller drives the rest.
interface guess_game_ctrl_if;
   logic       start;
   logic [5:0] ans_in;
   logic       guess_valid;
   logic [2:0] count_in;
   logic [5:0] ans;
   logic       ready;
   logic [2:0] attempts;
   logic [2:0] last_count;
   logic [2:0] best_count;
   logic       win;
   logic       lose;
   logic       done;
   logic       err;
   logic [1:0] dbg_state;

   modport master (
      output start, ans_in, guess_valid, count_in,
      input  ans, ready, attempts, last_count, best_count, win, lose, done, err, dbg_state
   );

   modport slave (
      input  start, ans_in, guess_valid, count_in,
      output ans, ready, attempts, last_count, best_count, win, lose, done, err, dbg_state
   );
endinterface

// File: rtl/guess_game_ctrl.sv
// Round controller for the guess match counter: latches the answer, scores strobed
// guesses, and ends the round in WIN or LOSE after at most MAX_TRIES attempts.
module guess_game_ctrl #(
   parameter int MAX_TRIES = 4,
   parameter int WIN_COUNT = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   guess_game_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_WIN  = 2'd2;
   localparam logic [1:0] S_LOSE = 2'd3;

   localparam logic [2:0] MAX_TRIES_C = 3'(MAX_TRIES);
   localparam logic [2:0] WIN_COUNT_C = 3'(WIN_COUNT);
   localparam logic [2:0] ILLEGAL_C   = 3'd7;

   logic [1:0] state_q, state_d;
   logic [5:0] ans_q, ans_d;
   logic [2:0] attempts_q, attempts_d;
   logic [2:0] last_q, last_d;
   logic [2:0] best_q, best_d;
   logic       err_q, err_d;
   logic [2:0] attempts_inc;

   assign attempts_inc = attempts_q + 3'd1;

   // Handshake: guess_valid is a one-cycle strobe with count_in valid in the same cycle;
   // it is consumed only while ready (PLAY) and silently dropped in every other state.
   always_comb begin
      state_d    = state_q;
      ans_d      = ans_q;
      attempts_d = attempts_q;
      last_d     = last_q;
      best_d     = best_q;
      err_d      = 1'b0;
      case (state_q)
         S_PLAY: begin
            if (bus.guess_valid) begin
               if (bus.count_in == ILLEGAL_C) begin
                  err_d = 1'b1;
               end else begin
                  attempts_d = attempts_inc;
                  last_d     = bus.count_in;
                  best_d     = (bus.count_in > best_q) ? bus.count_in : best_q;
                  // A win on the final attempt outranks running out of tries.
                  if (bus.count_in >= WIN_COUNT_C) begin
                     state_d = S_WIN;
                  end else if (attempts_inc == MAX_TRIES_C) begin
                     state_d = S_LOSE;
                  end
               end
            end
         end
         default: begin
            if (bus.start) begin
               state_d    = S_PLAY;
               ans_d      = bus.ans_in;
               attempts_d = 3'd0;
               last_d     = 3'd0;
               best_d     = 3'd0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ans_q      <= 6'd0;
         attempts_q <= 3'd0;
         last_q     <= 3'd0;
         best_q     <= 3'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ans_q      <= ans_d;
         attempts_q <= attempts_d;
         last_q     <= last_d;
         best_q     <= best_d;
         err_q      <= err_d;
      end
   end

   assign bus.ans        = ans_q;
   assign bus.ready      = (state_q == S_PLAY);
   assign bus.attempts   = attempts_q;
   assign bus.last_count = last_q;
   assign bus.best_count = best_q;
   assign bus.win        = (state_q == S_WIN);
   assign bus.lose       = (state_q == S_LOSE);
   assign bus.done       = (state_q == S_WIN) || (state_q == S_LOSE);
   assign bus.err        = err_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl with MAX_TRIES=4, WIN_COUNT=6.
module tb_guess_game_ctrl;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_WIN  = 2'd2;
   localparam logic [1:0] S_LOSE = 2'd3;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   guess_game_ctrl_if bus ();

   guess_game_ctrl #(.MAX_TRIES(4), .WIN_COUNT(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drivers: inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start       = 1'b0;
      bus.guess_valid = 1'b0;
      bus.count_in    = 3'd0;
   endtask

   task automatic do_start(input logic [5:0] a);
      bus.start  = 1'b1;
      bus.ans_in = a;
      step();
      idle_inputs();
   endtask

   task automatic do_guess(input logic [2:0] c);
      bus.guess_valid = 1'b1;
      bus.count_in    = c;
      step();
      idle_inputs();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      bus.ans_in = 6'h2a;
      repeat (2) step();
      total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, S_IDLE); end
      total++; if ({bus.ans, bus.attempts, bus.last_count, bus.best_count} !== 15'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {bus.ans, bus.attempts, bus.last_count, bus.best_count}); end
      total++; if ({bus.ready, bus.win, bus.lose, bus.done, bus.err} !== 5'd0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.ready, bus.win, bus.lose, bus.done, bus.err}); end
      #2 rst_n = 1'b1;
      do_guess(3'd3);
      total++; if (bus.attempts !== 3'd0 || bus.ready !== 1'b0) begin bad++; $display("FAIL idle_ignores_guess got att=%0d rdy=%0b exp att=0 rdy=0", bus.attempts, bus.ready); end
   endtask

   task automatic test_start();
      do_start(6'b111000);
      total++; if (bus.ready !== 1'b1) begin bad++; $display("FAIL start_ready got=%0b exp=1", bus.ready); end
      total++; if (bus.ans !== 6'b111000) begin bad++; $display("FAIL start_ans got=%b exp=111000", bus.ans); end
      total++; if (bus.attempts !== 3'd0 || bus.best_count !== 3'd0) begin bad++; $display("FAIL start_counters got att=%0d best=%0d exp 0 0", bus.attempts, bus.best_count); end
   endtask

   task automatic test_lose();
      bus.ans_in = 6'b000011;
      do_guess(3'd3);
      do_guess(3'd2);
      do_guess(3'd4);
      total++; if (bus.attempts !== 3'd3) begin bad++; $display("FAIL lose_att3 got=%0d exp=3", bus.attempts); end
      total++; if (bus.last_count !== 3'd4 || bus.best_count !== 3'd4) begin bad++; $display("FAIL lose_counts got last=%0d best=%0d exp 4 4", bus.last_count, bus.best_count); end
      total++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL lose_still_play got rdy=%0b done=%0b exp 1 0", bus.ready, bus.done); end
      total++; if (bus.ans !== 6'b111000) begin bad++; $display("FAIL ans_stable got=%b exp=111000", bus.ans); end
      do_guess(3'd1);
      total++; if ({bus.lose, bus.done, bus.ready, bus.win} !== 4'b1100) begin bad++; $display("FAIL lose_flags got=%b exp=1100", {bus.lose, bus.done, bus.ready, bus.win}); end
      total++; if (bus.attempts !== 3'd4 || bus.last_count !== 3'd1 || bus.best_count !== 3'd4) begin bad++; $display("FAIL lose_final got att=%0d last=%0d best=%0d exp 4 1 4", bus.attempts, bus.last_count, bus.best_count); end
      do_guess(3'd6);
      total++; if (bus.dbg_state !== S_LOSE || bus.attempts !== 3'd4) begin bad++; $display("FAIL lose_hold got st=%0d att=%0d exp %0d 4", bus.dbg_state, bus.attempts, S_LOSE); end
   endtask

   task automatic test_win();
      do_start(6'b010101);
      total++; if (bus.ans !== 6'b010101 || {bus.win, bus.lose, bus.done} !== 3'b000 || bus.ready !== 1'b1) begin bad++; $display("FAIL restart_from_lose got ans=%b wld=%b rdy=%0b exp 010101 000 1", bus.ans, {bus.win, bus.lose, bus.done}, bus.ready); end
      total++; if (bus.attempts !== 3'd0 || bus.last_count !== 3'd0 || bus.best_count !== 3'd0) begin bad++; $display("FAIL restart_clear got att=%0d last=%0d best=%0d exp 0 0 0", bus.attempts, bus.last_count, bus.best_count); end
      do_guess(3'd6);
      total++; if ({bus.win, bus.lose, bus.done, bus.ready} !== 4'b1010) begin bad++; $display("FAIL win_flags got=%b exp=1010", {bus.win, bus.lose, bus.done, bus.ready}); end
      total++; if (bus.attempts !== 3'd1 || bus.best_count !== 3'd6) begin bad++; $display("FAIL win_counts got att=%0d best=%0d exp 1 6", bus.attempts, bus.best_count); end
      do_guess(3'd2);
      total++; if (bus.win !== 1'b1 || bus.attempts !== 3'd1 || bus.last_count !== 3'd6) begin bad++; $display("FAIL win_hold got win=%0b att=%0d last=%0d exp 1 1 6", bus.win, bus.attempts, bus.last_count); end
   endtask

   task automatic test_err();
      do_start(6'b000111);
      do_guess(3'd2);
      bus.guess_valid = 1'b1;
      bus.count_in    = 3'd7;
      step();
      idle_inputs();
      total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%0b exp=1", bus.err); end
      total++; if (bus.attempts !== 3'd1 || bus.best_count !== 3'd2 || bus.last_count !== 3'd2 || bus.dbg_state !== S_PLAY) begin bad++; $display("FAIL err_hold got att=%0d best=%0d last=%0d st=%0d exp 1 2 2 1", bus.attempts, bus.best_count, bus.last_count, bus.dbg_state); end
      step();
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%0b exp=0", bus.err); end
   endtask

   task automatic test_start_with_guess();
      bus.start       = 1'b1;
      bus.ans_in      = 6'b101010;
      bus.guess_valid = 1'b1;
      bus.count_in    = 3'd5;
      step();
      idle_inputs();
      total++; if (bus.attempts !== 3'd2 || bus.best_count !== 3'd5 || bus.last_count !== 3'd5) begin bad++; $display("FAIL start_guess_counts got att=%0d best=%0d last=%0d exp 2 5 5", bus.attempts, bus.best_count, bus.last_count); end
      total++; if (bus.ans !== 6'b000111 || bus.ready !== 1'b1) begin bad++; $display("FAIL start_guess_ans got ans=%b rdy=%0b exp 000111 1", bus.ans, bus.ready); end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      total++; if (bus.dbg_state !== S_IDLE || {bus.ans, bus.attempts, bus.last_count, bus.best_count} !== 15'd0) begin bad++; $display("FAIL async_reset_regs got st=%0d regs=%h exp 0 0", bus.dbg_state, {bus.ans, bus.attempts, bus.last_count, bus.best_count}); end
      total++; if ({bus.ready, bus.win, bus.lose, bus.done, bus.err} !== 5'd0) begin bad++; $display("FAIL async_reset_flags got=%b exp=00000", {bus.ready, bus.win, bus.lose, bus.done, bus.err}); end
      #2 rst_n = 1'b1;
      do_guess(3'd3);
      total++; if (bus.attempts !== 3'd0 || bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL post_reset_ignore got att=%0d st=%0d exp 0 0", bus.attempts, bus.dbg_state); end
   endtask

   task automatic test_final_win();
      do_start(6'b110011);
      total++; if (bus.ans !== 6'b110011 || bus.ready !== 1'b1) begin bad++; $display("FAIL idle_start got ans=%b rdy=%0b exp 110011 1", bus.ans, bus.ready); end
      do_guess(3'd0);
      do_guess(3'd5);
      do_guess(3'd1);
      do_guess(3'd6);
      total++; if ({bus.win, bus.lose, bus.done} !== 3'b101 || bus.attempts !== 3'd4) begin bad++; $display("FAIL final_win got wld=%b att=%0d exp 101 4", {bus.win, bus.lose, bus.done}, bus.attempts); end
      total++; if (bus.best_count !== 3'd6 || bus.last_count !== 3'd6) begin bad++; $display("FAIL final_win_counts got best=%0d last=%0d exp 6 6", bus.best_count, bus.last_count); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_start();
      test_lose();
      test_win();
      test_err();
      test_start_with_guess();
      test_async_reset();
      test_final_win();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/guess_game_ctrl.md
Name: guess_game_ctrl

Overview:
- Sequential round controller that sits directly downstream of the `guess` match counter.
- Latches a 6-bit answer and drives it to the `guess` block.
- Accepts strobed guess submissions and consumes the 3-bit match count returned for each one.
- Tracks attempts and the best score, and declares a win or loss after at most MAX_TRIES attempts.

Parameters:
- MAX_TRIES, 4, attempts per round; legal range 1..7.
- WIN_COUNT, 6, match count that wins the round; legal range 1..6.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a new round; sampled at clk rise.
- ans_in  input  6  answer captured when start is accepted.
- guess_valid  input  1  one-cycle strobe: count_in holds the count for the current guess.
- count_in  input  3  match count from the `guess` block (combinational, same cycle).
- ans  output  6  latched answer, drives the `guess` block's ans input.
- ready  output  1  1 while in PLAY (controller accepts guesses).
- attempts  output  3  guesses consumed this round.
- last_count  output  3  count_in of the most recent accepted guess.
- best_count  output  3  maximum accepted count_in this round.
- win  output  1  held high in WIN.
- lose  output  1  held high in LOSE.
- done  output  1  win | lose.
- err  output  1  one-cycle pulse on an illegal count_in.

Behaviour:
- All outputs are registered (state-decoded outputs come from the state register).
- Reset (rst_n=0, asynchronous, any state, including mid-round):
  - state=IDLE.
  - ans, attempts, last_count and best_count = 0.
  - ready, win, lose, done and err = 0.
  - Outputs stay at these values until the first clk rise after rst_n=1.
- States: IDLE, PLAY, WIN, LOSE.
- IDLE:
  - guess_valid is ignored.
  - start=1 → ans<=ans_in; attempts, last_count and best_count <= 0; next state PLAY. ready rises one cycle after start.
- PLAY, with guess_valid=1 and count_in<=6 (accepted guess):
  - attempts<=attempts+1.
  - last_count<=count_in.
  - best_count<=max(best_count,count_in).
  - If count_in>=WIN_COUNT → WIN.
  - Else if attempts+1==MAX_TRIES → LOSE.
  - Else stay in PLAY.
  - Latency: win/lose/done are visible the cycle after the deciding strobe.
- PLAY, with guess_valid=1 and count_in==7 (illegal count):
  - err=1 for exactly one cycle.
  - attempts, last_count and best_count are unchanged; state is unchanged.
- PLAY, other inputs:
  - guess_valid=0 → hold all state.
  - start is ignored in PLAY. When start=1 and guess_valid=1 arrive together, only the guess is processed.
  - ans is stable for the whole round; ans_in changes have no effect.
- WIN and LOSE:
  - Outputs hold (ready=0, done=1); guess_valid is ignored.
  - start=1 → same action as in IDLE: new ans, counters cleared, win/lose/done fall, next state PLAY.
- Boundary cases:
  - MAX_TRIES=1: the first non-winning guess goes to LOSE.
  - A winning guess on the final attempt goes to WIN; win takes priority over lose.
  - attempts never exceeds MAX_TRIES, so the counter never wraps.
- err is 0 in every cycle other than the illegal-count cycle.

Test Plan:
- Reset then start, ans_in=6'b111000 → next cycle: ready=1, ans=6'b111000, attempts=0, best_count=0.
- In PLAY, strobe count_in=3, then 2, then 4 → attempts=3, last_count=4, best_count=4, ready still 1; a 4th strobe with count_in=1 → LOSE: lose=1, done=1, ready=0, attempts=4.
- New round via start in LOSE with ans_in=6'b010101, then strobe count_in=6 on attempt 1 → win=1, done=1, attempts=1; further guess_valid has no effect.
- In PLAY with attempts=1, strobe count_in=7 → err pulses for one cycle; attempts stays 1, best_count unchanged, still PLAY.
- In PLAY, start=1 together with guess_valid=1 and count_in=5 → guess processed (attempts+1, best_count=5); ans unchanged.
- In PLAY with attempts=2, drop rst_n asynchronously between clock edges → outputs are 0 immediately, state IDLE; guess_valid is ignored until start.
